// File: rtl/gt_tx_framer.sv
// GT transmit framer: wraps upstream beats in SOF/EOF control words,
// inserts inter-frame gap idles and periodic clock-correction words.
module gt_tx_framer #(
  parameter int unsigned GAP_WORDS   = 2,
  parameter int unsigned CC_INTERVAL = 5000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_link_up,
  input  logic [31:0] i_s_data,
  input  logic [3:0]  i_s_keep,
  input  logic        i_s_last,
  input  logic        i_s_valid,
  output logic        o_s_ready,
  output logic [31:0] o_tx_data,
  output logic [3:0]  o_tx_char,
  output logic        o_underrun,
  output logic        o_abort,
  output logic        o_keep_err
);

  localparam logic [31:0] W_IDLE = 32'h505050BC;
  localparam logic [31:0] W_SOF  = 32'h505050FB;
  localparam logic [31:0] W_CC   = 32'h1C1C1C1C;
  localparam logic [3:0]  K_CTL  = 4'b0001;
  localparam logic [3:0]  K_CC   = 4'b1111;
  localparam logic [3:0]  K_DAT  = 4'b0000;
  localparam logic [3:0]  GAP_W  = 4'(GAP_WORDS);
  localparam logic [15:0] CC_END = 16'(CC_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_EOF,
    S_GAP,
    S_DROP
  } state_t;

  state_t      r_state;
  logic [15:0] r_cc_cnt;
  logic        r_cc_pend;
  logic [3:0]  r_gap_cnt;
  logic [2:0]  r_nn;
  logic [31:0] r_tx_data;
  logic [3:0]  r_tx_char;
  logic        r_underrun;
  logic        r_abort;
  logic        r_keep_err;

  state_t      w_state_nxt;
  logic [3:0]  w_gap_nxt;
  logic [2:0]  w_nn_nxt;
  logic [31:0] w_data_nxt;
  logic [3:0]  w_char_nxt;
  logic        w_underrun_nxt;
  logic        w_abort_nxt;
  logic        w_keep_err_nxt;
  logic        w_cc_take;
  logic        w_cc_wrap;
  logic        w_ready;
  logic        w_accept;
  logic        w_keep_ok;
  logic [2:0]  w_keep_ones;
  logic [31:0] w_masked;
  logic [31:0] w_fill_data;
  logic [3:0]  w_fill_char;

  assign w_cc_wrap = (r_cc_cnt == CC_END);

  assign w_ready = !i_rst &&
    (((r_state == S_DATA) && i_link_up) || (r_state == S_DROP));

  assign w_accept = i_s_valid && w_ready;

  assign w_keep_ok = (i_s_keep == 4'b0001) || (i_s_keep == 4'b0011) ||
                     (i_s_keep == 4'b0111) || (i_s_keep == 4'b1111);

  assign w_keep_ones = {2'b00, i_s_keep[0]} + {2'b00, i_s_keep[1]} +
                       {2'b00, i_s_keep[2]} + {2'b00, i_s_keep[3]};

  assign w_masked = i_s_data & {{8{i_s_keep[3]}}, {8{i_s_keep[2]}},
                                {8{i_s_keep[1]}}, {8{i_s_keep[0]}}};

  // Filler slots carry a pending clock correction in preference to idle.
  assign w_fill_data = r_cc_pend ? W_CC : W_IDLE;
  assign w_fill_char = r_cc_pend ? K_CC : K_CTL;

  // Next-state and next-output decode for the framing FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_gap_nxt      = r_gap_cnt;
    w_nn_nxt       = r_nn;
    w_data_nxt     = W_IDLE;
    w_char_nxt     = K_CTL;
    w_underrun_nxt = 1'b0;
    w_abort_nxt    = 1'b0;
    w_keep_err_nxt = w_accept && !w_keep_ok;
    w_cc_take      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_link_up && i_s_valid && !r_cc_pend) begin
          w_data_nxt  = W_SOF;
          w_state_nxt = S_DATA;
        end else begin
          w_data_nxt = w_fill_data;
          w_char_nxt = w_fill_char;
          w_cc_take  = r_cc_pend;
        end
      end
      S_DATA: begin
        if (!i_link_up) begin
          w_data_nxt  = {16'h5050, 8'h00, 8'hFD};
          w_abort_nxt = 1'b1;
          if (w_accept && i_s_last) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_W;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (w_accept) begin
          w_data_nxt = w_masked;
          w_char_nxt = K_DAT;
          if (i_s_last) begin
            w_nn_nxt    = w_keep_ones;
            w_state_nxt = S_EOF;
          end
        end else begin
          w_underrun_nxt = 1'b1;
        end
      end
      S_EOF: begin
        w_data_nxt  = {16'h5050, 5'd0, r_nn, 8'hFD};
        w_gap_nxt   = GAP_W;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_data_nxt = w_fill_data;
        w_char_nxt = w_fill_char;
        w_cc_take  = r_cc_pend;
        w_gap_nxt  = r_gap_cnt - 4'd1;
        if (r_gap_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        w_data_nxt = w_fill_data;
        w_char_nxt = w_fill_char;
        w_cc_take  = r_cc_pend;
        if (w_accept && i_s_last) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_W;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered GT outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cc_cnt   <= 16'd0;
      r_cc_pend  <= 1'b0;
      r_gap_cnt  <= 4'd0;
      r_nn       <= 3'd0;
      r_tx_data  <= W_IDLE;
      r_tx_char  <= K_CTL;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_keep_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cc_cnt   <= w_cc_wrap ? 16'd0 : r_cc_cnt + 16'd1;
      r_cc_pend  <= w_cc_take ? 1'b0 : (r_cc_pend | w_cc_wrap);
      r_gap_cnt  <= w_gap_nxt;
      r_nn       <= w_nn_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_char  <= w_char_nxt;
      r_underrun <= w_underrun_nxt;
      r_abort    <= w_abort_nxt;
      r_keep_err <= w_keep_err_nxt;
    end
  end

  assign o_s_ready  = w_ready;
  assign o_tx_data  = r_tx_data;
  assign o_tx_char  = r_tx_char;
  assign o_underrun = r_underrun;
  assign o_abort    = r_abort;
  assign o_keep_err = r_keep_err;

endmodule

// File: doc/gt_tx_framer.md
GT_TX_FRAMER -- requirements
Module: gt_tx_framer

Interface
REQ-001 Parameter GAP_WORDS, default 2: idle words forced after every EOF word (range 1..15).
REQ-002 Parameter CC_INTERVAL, default 5000: cycles between clock-correction requests (range 16..65535).
REQ-003 i_clk  in  1  GT TX user clock; sole clock of the block.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_link_up  in  1  TX reset done and link usable.
REQ-006 i_s_data  in  32  upstream beat; byte0 = [7:0] is transmitted first.
REQ-007 i_s_keep  in  4  byte-valid mask; only 4'b0001, 4'b0011, 4'b0111 and 4'b1111 are legal.
REQ-008 i_s_last  in  1  final beat of the frame.
REQ-009 i_s_valid  in  1  beat present.
REQ-010 o_s_ready  out  1  beat accepted when i_s_valid and o_s_ready are both high.
REQ-011 o_tx_data  out  32  GT TX data word.
REQ-012 o_tx_char  out  4  per-byte K flag for o_tx_data.
REQ-013 o_underrun  out  1  one-cycle pulse on a mid-frame fill word.
REQ-014 o_abort  out  1  one-cycle pulse when a frame is cut by link loss.
REQ-015 o_keep_err  out  1  one-cycle pulse on an accepted illegal i_s_keep.

Function
REQ-016 Code words (data/char):
- IDLE = 32'h505050BC / 4'b0001
- SOF = 32'h505050FB / 4'b0001
- EOF = {16'h5050, 8'hNN, 8'hFD} / 4'b0001, where NN = valid-byte count of the last data word, 1..4, or 0 for abort
- CC = 32'h1C1C1C1C / 4'b1111
- DATA = beat / 4'b0000
REQ-017 o_tx_data, o_tx_char, o_underrun, o_abort and o_keep_err shall be registered; each output word reflects the state and inputs of the previous cycle.
REQ-018 States shall be IDLE, DATA, EOF, GAP and DROP.
REQ-019 IDLE behaviour:
- o_s_ready = 0.
- If i_link_up, i_s_valid and no pending CC: emit SOF and go to DATA.
- Otherwise emit CC if one is pending (this clears the pending flag), else emit IDLE.
REQ-020 DATA behaviour:
- o_s_ready = i_link_up.
- Accepted beat: emit DATA with bytes outside i_s_keep forced to 8'h00.
- Accepted beat with i_s_last: latch NN = number of ones in i_s_keep and go to EOF.
- No beat while i_link_up is high: emit IDLE and pulse o_underrun.
REQ-021 EOF: emit EOF with the latched NN, load the gap counter with GAP_WORDS, go to GAP.
REQ-022 GAP: emit IDLE, or CC if pending (this consumes one gap word); decrement the counter; go to IDLE when the counter reaches 0. o_s_ready = 0.
REQ-023 Illegal i_s_keep on an accepted beat: pulse o_keep_err; mask and NN shall use the number of ones in i_s_keep.
REQ-024 i_link_up low while in DATA:
- Emit EOF with NN = 0 and pulse o_abort.
- Go to DROP, unless this cycle's accepted beat was last, in which case go to GAP.
REQ-025 DROP: o_s_ready = 1; emit IDLE/CC; discard beats until an accepted i_s_last beat, then go to GAP with a counter of GAP_WORDS.
REQ-026 CC counter: a 16-bit free-running counter sets the pending flag on wrap at CC_INTERVAL-1. CC is never emitted in DATA or EOF. A new wrap while the flag is already set shall be ignored.
REQ-027 Latency: SOF appears 1 cycle after i_s_valid is sampled in IDLE; the first data beat is accepted on the next cycle and appears 1 cycle later. Frame overhead is 2 + GAP_WORDS words.
REQ-028 Simultaneous events: a single-beat frame (first beat with i_s_last) shall output SOF, DATA, EOF, then GAP. i_s_valid arriving during GAP shall wait in IDLE.

Reset
REQ-029 While i_rst is high:
- state = IDLE, CC counter = 0, pending = 0, gap counter = 0, NN = 0.
- o_tx_data = 32'h505050BC, o_tx_char = 4'b0001, o_s_ready = 0, all pulse outputs = 0.
REQ-030 Reset asserted mid-frame abandons the frame without emitting EOF. The first word after reset release shall be IDLE.

Verification
REQ-031 Single frame of 3 beats (last keep 4'b0011), GAP_WORDS = 2, link up:
- o_tx_data shall be 505050BC, 505050FB, D0, D1, D2 with bytes 3:2 zeroed, 505002FD, then 505050BC ×2.
- o_tx_char shall be 0001, 0001, 0000 ×3, 0001, 0001 ×2.
REQ-032 i_s_valid dropped for 2 cycles mid-frame -> two IDLE words inside the frame, o_underrun pulsed twice, data order preserved.
REQ-033 i_link_up deasserted after beat 2 of a 5-beat frame:
- 505000FD emitted and o_abort pulses once.
- Beats 3..5 are accepted and discarded.
- The next frame starts with SOF only after GAP_WORDS idles.
REQ-034 CC_INTERVAL = 16 with continuous back-to-back frames -> CC 1C1C1C1C/1111 appears only in IDLE/GAP slots, never between SOF and EOF, once per interval.
REQ-035 Accepted keep 4'b0101 on a last beat -> o_keep_err pulses, NN = 2, byte1 and byte3 zeroed.
REQ-036 i_rst pulsed in the middle of DATA -> next output 505050BC/0001 with o_s_ready = 0, and no EOF emitted for the abandoned frame.
